// File: rtl/m_mc_pkg.sv
// Shared definitions for the multi-cycle instruction controller:
// state encodings, opcode constants and the fetch timeout limit.
package m_mc_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned OP_W    = 7;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } mc_state_e;

   localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;
   localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

   // Fetch cycles without imem ready tolerated before declaring a timeout
   localparam int unsigned TMO_LIMIT = 16;
   localparam int unsigned TMO_W     = $clog2(TMO_LIMIT);

   // Stores and branches produce no register-file result
   function automatic logic op_writes_rf(input logic [OP_W-1:0] op);
      return !((op == OP_STORE) || (op == OP_BRANCH));
   endfunction

endpackage

// File: rtl/m_retire_cnt.sv
// Retired-instruction counter, wraps from all-ones to zero.
// Ports: clk, rst_n (async active-low), inc_i (count enable), count_o (count).
module m_retire_cnt #(
   parameter int unsigned RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                inc_i,
   output logic [RETIRE_W-1:0] count_o
);

   logic [RETIRE_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (inc_i) begin
         count_q <= count_q + RETIRE_W'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/m_mc_ctrl.sv
// Multi-cycle instruction controller: FETCH/DECODE/EXEC/WB sequencing with
// free-run and single-step modes, HALT on SYSTEM opcodes.
// Ports: w_clk, w_rst_n (async active-low), w_run, w_step, w_imem_rdy, w_ir_op
//        in; w_imem_req, w_ir_we, w_pc_we, w_rf_we (combinational decodes),
//        w_busy, w_halted, w_err, w_state, w_retired out.
// Optional: MC_CTRL_TIMEOUT_EN enables a fetch timeout that halts with w_err.
module m_mc_ctrl
   import m_mc_pkg::*;
#(
   parameter int unsigned RETIRE_W = 32
) (
   input  logic                w_clk,
   input  logic                w_rst_n,
   input  logic                w_run,
   input  logic                w_step,
   input  logic                w_imem_rdy,
   input  logic [OP_W-1:0]     w_ir_op,
   output logic                w_imem_req,
   output logic                w_ir_we,
   output logic                w_pc_we,
   output logic                w_rf_we,
   output logic                w_busy,
   output logic                w_halted,
   output logic                w_err,
   output logic [STATE_W-1:0]  w_state,
   output logic [RETIRE_W-1:0] w_retired
);

   mc_state_e state_q, state_d;
   // 1: free-run mode, 0: single-step mode; chosen when leaving IDLE
   logic      run_mode_q, run_mode_d;

`ifdef MC_CTRL_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
`endif

   // State and mode registers
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q    <= ST_IDLE;
         run_mode_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_mode_q <= run_mode_d;
      end
   end

`ifdef MC_CTRL_TIMEOUT_EN
   // Fetch timeout counter and sticky error flag
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
`endif

   // Next-state and datapath enable decode
   always_comb begin
      state_d    = state_q;
      run_mode_d = run_mode_q;
      w_imem_req = 1'b0;
      w_ir_we    = 1'b0;
      w_pc_we    = 1'b0;
      w_rf_we    = 1'b0;
`ifdef MC_CTRL_TIMEOUT_EN
      tmo_d      = tmo_q;
      err_d      = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // Run wins over step when both are requested
            if (w_run || w_step) begin
               state_d    = ST_FETCH;
               run_mode_d = w_run;
            end
         end
         ST_FETCH: begin
            w_imem_req = 1'b1;
            if (w_imem_rdy) begin
               w_ir_we = 1'b1;
               state_d = ST_DECODE;
            end else begin
`ifdef MC_CTRL_TIMEOUT_EN
               if (tmo_q == TMO_W'(TMO_LIMIT - 1)) begin
                  state_d = ST_HALT;
                  err_d   = 1'b1;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
`endif
            end
         end
         ST_DECODE: begin
            state_d = (w_ir_op == OP_SYSTEM) ? ST_HALT : ST_EXEC;
         end
         ST_EXEC: begin
            state_d = ST_WB;
         end
         ST_WB: begin
            w_pc_we = 1'b1;
            w_rf_we = op_writes_rf(w_ir_op);
            state_d = (run_mode_q && w_run) ? ST_FETCH : ST_IDLE;
         end
         ST_HALT: begin
            if (!w_run && !w_step) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
`ifdef MC_CTRL_TIMEOUT_EN
      // Each fetch starts with a fresh timeout window
      if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) begin
         tmo_d = '0;
      end
`endif
   end

   // Only WB retires; SYSTEM instructions never reach WB
   m_retire_cnt #(
      .RETIRE_W (RETIRE_W)
   ) u_retire_cnt (
      .clk     (w_clk),
      .rst_n   (w_rst_n),
      .inc_i   (state_q == ST_WB),
      .count_o (w_retired)
   );

   assign w_state  = state_q;
   assign w_busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                     (state_q == ST_EXEC)  || (state_q == ST_WB);
   assign w_halted = (state_q == ST_HALT);
`ifdef MC_CTRL_TIMEOUT_EN
   assign w_err    = err_q;
`else
   assign w_err    = 1'b0;
`endif

endmodule

// File: tb/tb_m_mc_ctrl.sv
// Self-checking bench for m_mc_ctrl with a narrow retired counter so that
// wrap-around is reachable.
module tb_m_mc_ctrl;

   localparam int unsigned RW   = 4;
   localparam int          RMOD = 1 << RW;
   localparam logic [6:0]  OP_ALU = 7'b0110011;
   localparam logic [6:0]  OP_LD  = 7'b0000011;
   localparam logic [6:0]  OP_ST  = 7'b0100011;
   localparam logic [6:0]  OP_BR  = 7'b1100011;
   localparam logic [6:0]  OP_SYS = 7'b1110011;

   logic          w_clk, w_rst_n, w_run, w_step, w_imem_rdy;
   logic [6:0]    w_ir_op;
   logic          w_imem_req, w_ir_we, w_pc_we, w_rf_we, w_busy, w_halted, w_err;
   logic [2:0]    w_state;
   logic [RW-1:0] w_retired;

   int   total = 0;
   int   bad   = 0;
   int   exp_ret = 0;
   logic exp_err = 1'b0;

   m_mc_ctrl #(.RETIRE_W(RW)) dut (
      .w_clk      (w_clk),
      .w_rst_n    (w_rst_n),
      .w_run      (w_run),
      .w_step     (w_step),
      .w_imem_rdy (w_imem_rdy),
      .w_ir_op    (w_ir_op),
      .w_imem_req (w_imem_req),
      .w_ir_we    (w_ir_we),
      .w_pc_we    (w_pc_we),
      .w_rf_we    (w_rf_we),
      .w_busy     (w_busy),
      .w_halted   (w_halted),
      .w_err      (w_err),
      .w_state    (w_state),
      .w_retired  (w_retired)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   function automatic logic [9:0] obs();
      return {w_state, w_imem_req, w_ir_we, w_pc_we, w_rf_we, w_busy, w_halted, w_err};
   endfunction

   // Expected output vector; busy/halted follow from the state by definition
   function automatic logic [9:0] expv(input int st, input logic req, input logic irwe,
                                       input logic pcwe, input logic rfwe);
      logic busy;
      logic halted;
      busy   = (st >= 1) && (st <= 4);
      halted = (st == 5);
      return {3'(st), req, irwe, pcwe, rfwe, busy, halted, exp_err};
   endfunction

   // Apply inputs for the coming cycle, then settle before sampling
   task automatic drive(input logic run, input logic step, input logic rdy, input logic [6:0] op);
      @(negedge w_clk);
      w_run = run; w_step = step; w_imem_rdy = rdy; w_ir_op = op;
      #1;
   endtask

   task automatic test_reset();
      @(negedge w_clk);
      w_rst_n = 1'b0; w_run = 1'b1; w_step = 1'b1; w_imem_rdy = 1'b1; w_ir_op = OP_ALU;
      #1;
      exp_ret = 0; exp_err = 1'b0;
      total++; if (obs() !== 10'd0) begin bad++; $display("FAIL reset_outs got %b want %b", obs(), 10'd0); end
      total++; if (w_retired !== RW'(0)) begin bad++; $display("FAIL reset_ret got %0d want 0", w_retired); end
      @(negedge w_clk); #1;
      total++; if (obs() !== 10'd0) begin bad++; $display("FAIL reset_hold got %b want %b", obs(), 10'd0); end
      @(negedge w_clk);
      w_rst_n = 1'b1; w_run = 1'b0; w_step = 1'b0; w_imem_rdy = 1'b0;
      #1;
      total++; if (obs() !== expv(0,0,0,0,0)) begin bad++; $display("FAIL reset_idle got %b want %b", obs(), expv(0,0,0,0,0)); end
   endtask

   task automatic test_run10();
      int rf_cnt, pc_cnt;
      rf_cnt = 0; pc_cnt = 0;
      drive(1, 0, 1, OP_ALU);
      total++; if (obs() !== expv(0,0,0,0,0)) begin bad++; $display("FAIL run10_idle got %b want %b", obs(), expv(0,0,0,0,0)); end
      for (int i = 0; i < 40; i++) begin
         drive(i < 39, 0, 1, OP_ALU);
         total++;
         if (w_state !== 3'((i % 4) + 1)) begin bad++; $display("FAIL run10_state cyc=%0d got %0d want %0d", i, w_state, (i % 4) + 1); end
         rf_cnt += int'(w_rf_we);
         pc_cnt += int'(w_pc_we);
      end
      exp_ret = (exp_ret + 10) % RMOD;
      drive(0, 0, 0, OP_ALU);
      total++; if (w_state !== 3'd0) begin bad++; $display("FAIL run10_end got %0d want 0", w_state); end
      total++; if (w_retired !== RW'(exp_ret)) begin bad++; $display("FAIL run10_ret got %0d want %0d", w_retired, exp_ret); end
      total++; if (rf_cnt !== 10) begin bad++; $display("FAIL run10_rf got %0d want 10", rf_cnt); end
      total++; if (pc_cnt !== 10) begin bad++; $display("FAIL run10_pc got %0d want 10", pc_cnt); end
   endtask

   task automatic test_step();
      int seq [5] = '{1, 2, 3, 4, 0};
      int pc_cnt;
      pc_cnt = 0;
      drive(0, 1, 1, OP_ALU);
      total++; if (w_state !== 3'd0) begin bad++; $display("FAIL step_idle got %0d want 0", w_state); end
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 1, OP_ALU);
         total++; if (w_state !== 3'(seq[i])) begin bad++; $display("FAIL step_seq i=%0d got %0d want %0d", i, w_state, seq[i]); end
         pc_cnt += int'(w_pc_we);
      end
      exp_ret = (exp_ret + 1) % RMOD;
      total++; if (pc_cnt !== 1) begin bad++; $display("FAIL step_pc got %0d want 1", pc_cnt); end
      total++; if (w_retired !== RW'(exp_ret)) begin bad++; $display("FAIL step_ret got %0d want %0d", w_retired, exp_ret); end
      drive(0, 0, 1, OP_ALU);
      total++; if (w_state !== 3'd0) begin bad++; $display("FAIL step_stay got %0d want 0", w_state); end
   endtask

   task automatic test_both();
      int seq [10] = '{1, 2, 3, 4, 1, 2, 3, 4, 0, 0};
      drive(1, 1, 1, OP_ALU);
      total++; if (w_state !== 3'd0) begin bad++; $display("FAIL both_idle got %0d want 0", w_state); end
      for (int i = 0; i < 10; i++) begin
         drive(i < 4, 0, 1, OP_ALU);
         total++; if (w_state !== 3'(seq[i])) begin bad++; $display("FAIL both_seq i=%0d got %0d want %0d", i, w_state, seq[i]); end
      end
      exp_ret = (exp_ret + 2) % RMOD;
      total++; if (w_retired !== RW'(exp_ret)) begin bad++; $display("FAIL both_ret got %0d want %0d", w_retired, exp_ret); end
   endtask

   // Free-run stream of random non-SYSTEM opcodes with random fetch waits
   task automatic test_random();
      logic [6:0] pool [4] = '{OP_ALU, OP_LD, OP_ST, OP_BR};
      logic [6:0] op;
      logic       run, rf;
      int         wt;
      int         n;
      n = 24;
      drive(1, 0, 0, OP_ALU);
      total++; if (obs() !== expv(0,0,0,0,0)) begin bad++; $display("FAIL rnd_idle got %b want %b", obs(), expv(0,0,0,0,0)); end
      for (int k = 0; k < n; k++) begin
         op = pool[$urandom_range(0, 3)];
         wt = $urandom_range(0, 5);
         for (int w = 0; w <= wt; w++) begin
            drive(1, 1'($urandom_range(0, 1)), w == wt, op);
            total++; if (obs() !== expv(1, 1, w == wt, 0, 0)) begin bad++; $display("FAIL rnd_fetch k=%0d got %b want %b", k, obs(), expv(1, 1, w == wt, 0, 0)); end
            if (w == 0) begin
               total++; if (w_retired !== RW'(exp_ret)) begin bad++; $display("FAIL rnd_ret k=%0d got %0d want %0d", k, w_retired, exp_ret); end
            end
         end
         // Last instruction drops run from DECODE onward but must still complete
         run = (k != n - 1);
         drive(run, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op);
         total++; if (obs() !== expv(2,0,0,0,0)) begin bad++; $display("FAIL rnd_dec k=%0d got %b want %b", k, obs(), expv(2,0,0,0,0)); end
         drive(run, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op);
         total++; if (obs() !== expv(3,0,0,0,0)) begin bad++; $display("FAIL rnd_exec k=%0d got %b want %b", k, obs(), expv(3,0,0,0,0)); end
         rf = !((op == OP_ST) || (op == OP_BR));
         drive(run, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op);
         total++; if (obs() !== expv(4,0,0,1,rf)) begin bad++; $display("FAIL rnd_wb k=%0d op=%b got %b want %b", k, op, obs(), expv(4,0,0,1,rf)); end
         exp_ret = (exp_ret + 1) % RMOD;
      end
      drive(0, 0, 0, OP_ALU);
      total++; if (obs() !== expv(0,0,0,0,0)) begin bad++; $display("FAIL rnd_end got %b want %b", obs(), expv(0,0,0,0,0)); end
      total++; if (w_retired !== RW'(exp_ret)) begin bad++; $display("FAIL rnd_endret got %0d want %0d", w_retired, exp_ret); end
   endtask

   task automatic test_system();
      drive(1, 0, 1, OP_SYS);
      drive(1, 0, 1, OP_SYS);
      total++; if (obs() !== expv(1,1,1,0,0)) begin bad++; $display("FAIL sys_fetch got %b want %b", obs(), expv(1,1,1,0,0)); end
      drive(1, 0, 1, OP_SYS);
      total++; if (obs() !== expv(2,0,0,0,0)) begin bad++; $display("FAIL sys_dec got %b want %b", obs(), expv(2,0,0,0,0)); end
      for (int i = 0; i < 3; i++) begin
         drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), OP_SYS);
         total++; if (obs() !== expv(5,0,0,0,0)) begin bad++; $display("FAIL sys_halt i=%0d got %b want %b", i, obs(), expv(5,0,0,0,0)); end
      end
      drive(0, 1, 1, OP_SYS);
      total++; if (obs() !== expv(5,0,0,0,0)) begin bad++; $display("FAIL sys_hstep got %b want %b", obs(), expv(5,0,0,0,0)); end
      drive(0, 0, 0, OP_SYS);
      total++; if (obs() !== expv(5,0,0,0,0)) begin bad++; $display("FAIL sys_hlast got %b want %b", obs(), expv(5,0,0,0,0)); end
      total++; if (w_retired !== RW'(exp_ret)) begin bad++; $display("FAIL sys_ret got %0d want %0d", w_retired, exp_ret); end
      drive(0, 0, 0, OP_ALU);
      total++; if (obs() !== expv(0,0,0,0,0)) begin bad++; $display("FAIL sys_idle got %b want %b", obs(), expv(0,0,0,0,0)); end
   endtask

   task automatic test_timeout();
      drive(1, 0, 0, OP_ALU);
      for (int c = 1; c <= 20; c++) begin
         drive(1, 0, 0, OP_ALU);
`ifdef MC_CTRL_TIMEOUT_EN
         if (c > 16) exp_err = 1'b1;
         total++; if (obs() !== expv((c <= 16) ? 1 : 5, c <= 16, 0, 0, 0)) begin bad++; $display("FAIL tmo_cyc c=%0d got %b want %b", c, obs(), expv((c <= 16) ? 1 : 5, c <= 16, 0, 0, 0)); end
`else
         total++; if (obs() !== expv(1,1,0,0,0)) begin bad++; $display("FAIL tmo_wait c=%0d got %b want %b", c, obs(), expv(1,1,0,0,0)); end
`endif
      end
`ifdef MC_CTRL_TIMEOUT_EN
      drive(0, 0, 0, OP_ALU);
      total++; if (obs() !== expv(5,0,0,0,0)) begin bad++; $display("FAIL tmo_halt got %b want %b", obs(), expv(5,0,0,0,0)); end
      drive(0, 0, 0, OP_ALU);
      total++; if (obs() !== expv(0,0,0,0,0)) begin bad++; $display("FAIL tmo_sticky got %b want %b", obs(), expv(0,0,0,0,0)); end
`else
      drive(0, 0, 1, OP_ALU);
      total++; if (obs() !== expv(1,1,1,0,0)) begin bad++; $display("FAIL tmo_rdy got %b want %b", obs(), expv(1,1,1,0,0)); end
      drive(0, 0, 0, OP_ALU);
      drive(0, 0, 0, OP_ALU);
      drive(0, 0, 0, OP_ALU);
      total++; if (obs() !== expv(4,0,0,1,1)) begin bad++; $display("FAIL tmo_wb got %b want %b", obs(), expv(4,0,0,1,1)); end
      exp_ret = (exp_ret + 1) % RMOD;
      drive(0, 0, 0, OP_ALU);
      total++; if (obs() !== expv(0,0,0,0,0)) begin bad++; $display("FAIL tmo_idle got %b want %b", obs(), expv(0,0,0,0,0)); end
      total++; if (w_retired !== RW'(exp_ret)) begin bad++; $display("FAIL tmo_ret got %0d want %0d", w_retired, exp_ret); end
`endif
   endtask

   task automatic test_reset_exec();
      test_reset();
      drive(1, 0, 1, OP_ALU);
      for (int i = 0; i < 23; i++) drive(1, 0, 1, OP_ALU);
      total++; if (w_state !== 3'd3) begin bad++; $display("FAIL rexec_state got %0d want 3", w_state); end
      total++; if (w_retired !== RW'(5)) begin bad++; $display("FAIL rexec_ret got %0d want 5", w_retired); end
      w_rst_n = 1'b0;
      #1;
      exp_ret = 0; exp_err = 1'b0;
      total++; if (obs() !== 10'd0) begin bad++; $display("FAIL rexec_async got %b want %b", obs(), 10'd0); end
      total++; if (w_retired !== RW'(0)) begin bad++; $display("FAIL rexec_clr got %0d want 0", w_retired); end
      test_reset();
   endtask

   initial begin
      w_rst_n = 1'b0; w_run = 1'b0; w_step = 1'b0; w_imem_rdy = 1'b0; w_ir_op = 7'd0;
      test_reset();
      test_run10();
      test_step();
      test_both();
      test_random();
      test_system();
      test_timeout();
      test_reset_exec();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/m_mc_ctrl.md
M_MC_CTRL -- requirements
Module: m_mc_ctrl

Interface
REQ-001 SHALL have parameter RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port w_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port w_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port w_run  input  1  level, free-run enable.
REQ-005 SHALL have port w_step  input  1  single-instruction request, sampled in IDLE only.
REQ-006 SHALL have port w_imem_rdy  input  1  instruction memory data valid.
REQ-007 SHALL have port w_ir_op  input  7  opcode field of the latched instruction register.
REQ-008 SHALL have port w_imem_req  output  1  fetch request to instruction memory.
REQ-009 SHALL have ports w_ir_we, w_pc_we, w_rf_we  output  1 each  datapath write enables (IR, PC, register file).
REQ-010 SHALL have ports w_busy, w_halted, w_err  output  1 each  status flags.
REQ-011 SHALL have ports w_state  output  3  current state code, and w_retired  output  RETIRE_W  retired-instruction count.

Function
REQ-012 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-013 IDLE SHALL go to FETCH when w_run or w_step is 1; if both are 1, run mode SHALL apply and the step request SHALL be dropped.
REQ-014 FETCH SHALL drive w_imem_req=1 every cycle and hold until w_imem_rdy=1; in that cycle w_ir_we=1 and the next state SHALL be DECODE.
REQ-015 DECODE SHALL go to HALT when w_ir_op=7'b1110011 (SYSTEM), else to EXEC.
REQ-016 EXEC SHALL go to WB unconditionally; each instruction takes exactly one EXEC cycle.
REQ-017 WB SHALL drive w_pc_we=1.
REQ-018 WB SHALL drive w_rf_we=1 unless w_ir_op is 7'b0100011 (STORE) or 7'b1100011 (BRANCH).
REQ-019 WB SHALL increment w_retired by 1, wrapping from all-ones to 0.
REQ-020 After WB the next state SHALL be FETCH if in run mode and w_run=1, else IDLE; a step therefore retires exactly one instruction.
REQ-021 Dropping w_run mid-instruction SHALL NOT abort the instruction; the controller SHALL complete WB, then enter IDLE.
REQ-022 HALT SHALL assert w_halted=1 and hold all write enables at 0.
REQ-023 HALT SHALL go to IDLE only when w_run=0 and w_step=0.
REQ-024 A SYSTEM instruction SHALL NOT retire and SHALL NOT advance the PC.
REQ-025 w_busy SHALL be 1 in FETCH, DECODE, EXEC and WB, else 0.
REQ-026 w_ir_we, w_pc_we, w_rf_we and w_imem_req SHALL be combinational decodes of state and inputs, with no extra latency.
REQ-027 Minimum instruction latency SHALL be 4 cycles (FETCH with w_imem_rdy=1 on its first cycle).

Reset
REQ-028 When w_rst_n=0, the controller SHALL immediately enter IDLE and clear the run/step mode flag, w_retired, w_err and the timeout counter, regardless of current state.
REQ-029 During reset all outputs SHALL be 0 except w_state=0.

Configuration
REQ-030 Macro MC_CTRL_TIMEOUT_EN defined: a 4-bit counter SHALL count FETCH cycles without w_imem_rdy.
REQ-031 Macro MC_CTRL_TIMEOUT_EN defined: on the 16th consecutive such cycle the controller SHALL go to HALT and set w_err=1, sticky until reset.
REQ-032 Macro MC_CTRL_TIMEOUT_EN defined: the timeout counter SHALL clear on entry to FETCH.
REQ-033 Macro MC_CTRL_TIMEOUT_EN undefined: FETCH SHALL wait indefinitely and w_err SHALL be constant 0.

Structure
REQ-034 Shared package m_mc_pkg SHALL hold the state encodings, the opcode constants (SYSTEM, STORE, BRANCH) and the timeout limit of 16.
REQ-035 The retired counter SHALL be a sub-module m_retire_cnt (parameter RETIRE_W, ports: clock, reset, increment enable, count).

Verification
REQ-036 Reset, then w_run=1, w_imem_rdy=1, opcode 0110011 for 10 instructions -> w_retired=10 after 40 cycles, w_rf_we pulsed 10 times.
REQ-037 IDLE, 1-cycle w_step pulse with w_run=0 -> state sequence 1,2,3,4,0, w_retired=1, w_pc_we exactly one pulse.
REQ-038 Run with opcode 1100011 -> w_pc_we=1 and w_rf_we=0 in every WB cycle.
REQ-039 Fetch with opcode 1110011 -> HALT, w_halted=1, w_retired unchanged; then w_run=0 -> IDLE next cycle.
REQ-040 w_imem_rdy held 0 for 20 cycles -> with MC_CTRL_TIMEOUT_EN: HALT and w_err=1 after 16 cycles; without it: still in FETCH and w_err=0.
REQ-041 w_rst_n=0 asserted in EXEC with w_retired=5 -> immediately w_state=0 and w_retired=0.
